// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, and buffers one instruction for IF/ID.
// Optional perf counters (fetch_cnt_o, bubble_cnt_o) are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        jump_i,
  input  logic [25:0] jump_addr_i,
  input  logic [31:0] id_pc4_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        flush_o,
  output logic [1:0]  dbg_state_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2, FULL = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic        buf_valid_q, buf_valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        unused_pc4_low;

  assign redirect       = ~stall_i & (jump_i | branch_i);
  assign target         = jump_i ? {id_pc4_i[31:28], jump_addr_i, 2'b00} : branch_addr_i;
  assign pc_plus4       = pc_q + 32'd4;
  assign unused_pc4_low = ^id_pc4_i[27:0];

  // Handshake: imem_req_o stays high with imem_addr_o held until a cycle with imem_ack_i=1;
  // that cycle transfers imem_rdata_i. An ack seen while req is low is ignored.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    buf_d       = buf_q;
    buf_pc4_d   = buf_pc4_q;
    buf_valid_d = buf_valid_q;
    imem_req_o  = 1'b0;
    flush_o     = 1'b1;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          if (redirect) begin
            pc_d = target;
          end else begin
            buf_d       = imem_rdata_i;
            buf_pc4_d   = pc_plus4;
            buf_valid_d = 1'b1;
            pc_d        = pc_plus4;
            state_d     = FULL;
          end
        end else if (redirect) begin
          tgt_d   = target;
          state_d = DROP;
        end
      end
      DROP: begin
        // Old request must complete before the redirect target can be issued.
        imem_req_o = 1'b1;
        if (redirect) tgt_d = target;
        if (imem_ack_i) begin
          pc_d    = redirect ? target : tgt_q;
          state_d = REQ;
        end
      end
      FULL: begin
        flush_o = redirect;
        if (!stall_i) begin
          buf_valid_d = 1'b0;
          state_d     = REQ;
          if (redirect) pc_d = target;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      tgt_q       <= RESET_PC;
      buf_q       <= 32'h0;
      buf_pc4_q   <= 32'h0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_q       <= buf_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign inst_o      = buf_valid_q ? buf_q : 32'h0;
  assign inst_addr_o = buf_valid_q ? buf_pc4_q : 32'h0;
  assign dbg_state_o = state_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (state_q == FULL && !stall_i && !redirect && fetch_cnt_q != 32'hFFFF_FFFF)
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (flush_o && !stall_i && bubble_cnt_q != 32'hFFFF_FFFF)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes expected fetch addresses and delivered
// instructions into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, branch_i, jump_i, imem_ack_i;
  logic [31:0] branch_addr_i, id_pc4_i, imem_rdata_i;
  logic [25:0] jump_addr_i;
  logic        imem_req_o, flush_o;
  logic [31:0] imem_addr_o, inst_o, inst_addr_o;
  logic [1:0]  dbg_state_o;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_o, bubble_cnt_o;
`endif

  logic [31:0] exp_req_q[$];
  logic [63:0] exp_inst_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i), .id_pc4_i(id_pc4_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .flush_o(flush_o),
    .dbg_state_o(dbg_state_o)
`ifdef IF_FETCH_PERF_EN
    , .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
    imem_ack_i = 1'b0;
    branch_i   = 1'b0;
    jump_i     = 1'b0;
    stall_i    = 1'b0;
  endtask

  task automatic give_ack(input logic [31:0] data);
    imem_ack_i   = 1'b1;
    imem_rdata_i = data;
  endtask

  task automatic do_branch(input logic [31:0] addr);
    branch_i      = 1'b1;
    branch_addr_i = addr;
  endtask

  // scoreboard monitor
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk_i) begin
    if (imem_req_o && (!prev_req || prev_ack)) begin
      if (exp_req_q.size() == 0) chk("req_unexpected", 64'(imem_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("req_addr", 64'(imem_addr_o), 64'(exp_req_q.pop_front()));
    end
    if (imem_req_o && prev_req && !prev_ack)
      chk("req_addr_stable", 64'(imem_addr_o), 64'(prev_addr));
    if (imem_req_o)
      chk("inst_nop_while_req", {inst_o, inst_addr_o}, 64'h0);
    if (!flush_o && !stall_i) begin
      if (exp_inst_q.size() == 0) chk("inst_unexpected", {inst_o, inst_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("inst_consume", {inst_o, inst_addr_o}, exp_inst_q.pop_front());
    end
    prev_req  <= imem_req_o;
    prev_ack  <= imem_req_o & imem_ack_i;
    prev_addr <= imem_addr_o;
  end

  // stimulus
  initial begin
    rst_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0; imem_ack_i = 1'b0;
    branch_addr_i = 32'h0; id_pc4_i = 32'h0; jump_addr_i = 26'h0; imem_rdata_i = 32'h0;
    #1;
    chk("rst_req", 64'(imem_req_o), 64'd0);
    chk("rst_flush", 64'(flush_o), 64'd1);
    chk("rst_inst", {inst_o, inst_addr_o}, 64'h0);
    chk("rst_addr", 64'(imem_addr_o), 64'h0);
    chk("rst_state_idle", 64'(dbg_state_o), 64'd0);
    next_cycle();
    next_cycle();
    rst_i = 1'b1;
    exp_req_q.push_back(32'h0);
    #1 chk("idle_req", 64'(imem_req_o), 64'd0);
    next_cycle();
    // sequential fetch
    give_ack(32'h2008_0005);
    exp_inst_q.push_back({32'h2008_0005, 32'h4});
    exp_req_q.push_back(32'h4);
    next_cycle();
    #1 chk("full_flush", 64'(flush_o), 64'd0);
    next_cycle();
    // stall in FULL, including a branch that must be ignored
    give_ack(32'h1111_1111);
    exp_inst_q.push_back({32'h1111_1111, 32'h8});
    exp_req_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      stall_i = 1'b1;
      if (i == 1) do_branch(32'h80);
      #1;
      chk("stall_inst", {inst_o, inst_addr_o}, {32'h1111_1111, 32'h8});
      chk("stall_req", 64'(imem_req_o), 64'd0);
      chk("stall_flush", 64'(flush_o), 64'd0);
    end
    next_cycle();
    next_cycle();
    // branch in FULL flushes the buffer
    give_ack(32'h2222_2222);
    exp_req_q.push_back(32'h40);
    next_cycle();
    do_branch(32'h40);
    #1 chk("branch_full_flush", 64'(flush_o), 64'd1);
    next_cycle();
    // ack with redirect: data discarded, new address next cycle
    give_ack(32'h5555_5555);
    do_branch(32'h8);
    exp_req_q.push_back(32'h8);
    next_cycle();
    // jump while outstanding; branch at the same time loses
    jump_i = 1'b1; jump_addr_i = 26'h10; id_pc4_i = 32'h1000_0008;
    do_branch(32'h80);
    exp_req_q.push_back(32'h1000_0040);
    next_cycle();
    #1 chk("drop_flush", 64'(flush_o), 64'd1);
    chk("drop_req", 64'(imem_req_o), 64'd1);
    next_cycle();
    give_ack(32'hDEAD_BEEF);
    #1 chk("drop_ack_flush", 64'(flush_o), 64'd1);
    next_cycle();
    // PC wrap at the top of the address space
    give_ack(32'h6666_6666);
    do_branch(32'hFFFF_FFFC);
    exp_req_q.push_back(32'hFFFF_FFFC);
    next_cycle();
    give_ack(32'h3333_3333);
    exp_inst_q.push_back({32'h3333_3333, 32'h0});
    exp_req_q.push_back(32'h0);
    next_cycle();
    next_cycle();
    // redirect in DROP overwrites the pending target
    do_branch(32'h100);
    exp_req_q.push_back(32'h200);
    next_cycle();
    do_branch(32'h200);
    next_cycle();
    give_ack(32'h7777_7777);
    next_cycle();
    // reset during DROP
    jump_i = 1'b1; jump_addr_i = 26'h3; id_pc4_i = 32'h0;
    next_cycle();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_req", 64'(imem_req_o), 64'd0);
    chk("mid_rst_flush", 64'(flush_o), 64'd1);
    chk("mid_rst_pc", 64'(imem_addr_o), 64'h0);
    next_cycle();
    rst_i = 1'b1;
    give_ack(32'h9999_9999);
    exp_req_q.push_back(32'h0);
    #1 chk("late_ack_idle_req", 64'(imem_req_o), 64'd0);
    next_cycle();
    give_ack(32'h4444_4444);
    exp_inst_q.push_back({32'h4444_4444, 32'h4});
    exp_req_q.push_back(32'h4);
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    chk("exp_req_q_empty", 64'(exp_req_q.size()), 64'd0);
    chk("exp_inst_q_empty", 64'(exp_inst_q.size()), 64'd0);
`ifdef IF_FETCH_PERF_EN
    chk("fetch_cnt", 64'(fetch_cnt_o), 64'd1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
